uart_tx_drain: RTL and testbench
================================

# uart_tx_drain

UART transmitter that drains the byte FIFO's read port and serialises each word onto a single `tx` line. It sits directly downstream of the `fifo` block: it watches `empty`, pops one word with a single-cycle `rd` pulse, and shifts it out as a standard async frame. It keeps `rd` low while a frame is in flight, so the FIFO absorbs producer bursts.

## Interface

Parameters:
- `DBIT`, 8, data bits per frame; must equal the FIFO `WORD_LEN`.
- `CLKS_PER_BIT`, 434, clock cycles per bit period (50 MHz / 115200); legal range 2..65535.
- `PARITY`, 0, 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1, number of stop bits, 1 or 2.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `empty`  in  1  FIFO empty flag.
- `r_data`  in  DBIT  FIFO head word; valid whenever `empty` = 0.
- `rd`  out  1  FIFO pop strobe, one cycle per frame.
- `tx`  out  1  serial line; idle high.
- `tx_busy`  out  1  high from the cycle after the pop until the frame ends.
- `tx_done_tick`  out  1  one-cycle pulse in the final cycle of the last stop bit.

## Operation

- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: `tx` = 1 and `tx_busy` = 0.
  - `rd` = 1 combinationally when `empty` = 0 and `reset` = 1.
  - On that edge, `r_data` latches into the shift register, the bit counter clears, the tick counter clears, and the state goes to START.
- START: `tx` = 0 for `CLKS_PER_BIT` cycles, then DATA.
- DATA: `tx` = shift-register bit 0 (LSB first).
  - Every `CLKS_PER_BIT` cycles: shift right, increment the bit counter.
  - After `DBIT` bits, go to PARITY if `PARITY` ≠ 0, else to STOP.
- PARITY: `tx` = XOR of all data bits for even; the inverse of that XOR for odd. Lasts one bit period, then STOP.
- STOP: `tx` = 1 for `STOP_BITS` × `CLKS_PER_BIT` cycles.
  - `tx_done_tick` = 1 in the last cycle of STOP.
  - Then IDLE.
- `tx` is registered and glitch-free. `tx_busy` = 1 in every state except IDLE.
- Tick counter width is `$clog2(CLKS_PER_BIT)`. Bit counter width is `$clog2(DBIT+1)`.
- `rd` never asserts outside IDLE, so the block never pops an empty FIFO or pops twice per frame.

## Timing

- Reset values: `tx` = 1, `rd` = 0, `tx_busy` = 0, `tx_done_tick` = 0, state IDLE.
  - `rd` is held 0 for as long as `reset` is low, regardless of `empty`.
- Pop latency: when `empty` falls in IDLE, `rd` is high in that same cycle. The start bit begins on the next edge.
- Frame length: (1 + `DBIT` + (`PARITY`≠0) + `STOP_BITS`) × `CLKS_PER_BIT` cycles, measured from the first start-bit cycle.
- Back-to-back frames: exactly one IDLE cycle (`tx` = 1) separates the end of a stop bit from the next start bit. Successive `rd` pulses are therefore (frame length + 1) cycles apart.
- Changes on `empty` and `r_data` outside IDLE are ignored.
- Reset asserted mid-frame:
  - Immediate return to IDLE, with `tx` = 1 and no `tx_done_tick`.
  - The popped byte is dropped, not re-fetched.
- After `reset` deasserts with `empty` = 0, a pop occurs in the first cycle.

## Test plan

All scenarios use `CLKS_PER_BIT` = 4 and `DBIT` = 8.

- Reset with `empty` = 1, then `empty` = 0 while still in reset → `tx` = 1, `rd` = 0, `tx_busy` = 0 throughout the reset.
- Single byte 0xA5, `PARITY` = 0, `STOP_BITS` = 1:
  - `rd` pulses for exactly one cycle.
  - `tx` bits are 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  - `tx_done_tick` is in cycle 40 after the pop.
- Bytes 0x01, 0x02, 0x03 queued in the FIFO:
  - Three `rd` pulses, 41 cycles apart.
  - One idle-high cycle between frames.
  - Decoded bytes are 0x01, 0x02, 0x03 in order.
- Byte 0x07 sent twice:
  - `PARITY` = 2 → parity bit 1.
  - `PARITY` = 1 → parity bit 0.
  - `STOP_BITS` = 2 → stop high for 8 cycles.
- Reset during data bit 3 of 0xFF:
  - `tx` = 1 immediately; no `tx_done_tick`.
  - After release with 0x55 at the FIFO head, a new pop occurs and 0x55 is framed correctly.
- `empty` toggled and `r_data` changed mid-frame → no extra `rd` pulse, and the transmitted byte equals the value latched at the pop.

Source files
------------

// File: rtl/uart_tx_drain.sv
// UART transmitter that pops one word from an upstream FIFO and serialises it
// as start / data (LSB first) / optional parity / stop bits on a registered tx line.
//
// state    | meaning
// ---------+--------------------------------------------------
// S_IDLE   | line high, pop the FIFO head as soon as it is non-empty
// S_START  | start bit (tx low) for one bit period
// S_DATA   | DBIT data bits, LSB first, one bit period each
// S_PARITY | optional parity bit, one bit period
// S_STOP   | STOP_BITS stop bits (tx high); done tick in the last cycle
module uart_tx_drain #(
  parameter int DBIT         = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            empty,
  input  logic [DBIT-1:0] r_data,
  output logic            rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DBIT + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DBIT - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DBIT-1:0] sreg_q, sreg_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic            tick_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      sreg_q  <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    bit_d        = bit_q;
    sreg_d       = sreg_q;
    par_d        = par_q;
    rd           = 1'b0;
    tx_done_tick = 1'b0;
    tick_last    = (tick_q == TICK_LAST);

    case (state_q)
      S_IDLE: begin
        if (!empty && reset) begin
          rd      = 1'b1;
          sreg_d  = r_data;
          par_d   = ^r_data;
          bit_d   = '0;
          tick_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick_last) begin
          tick_d  = '0;
          state_d = S_DATA;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_DATA: begin
        if (tick_last) begin
          tick_d = '0;
          sreg_d = sreg_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (tick_last) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = S_STOP;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_STOP: begin
        if (tick_last) begin
          tick_d = '0;
          if (bit_q == STOP_LAST) begin
            tx_done_tick = 1'b1;
            state_d      = S_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // tx is driven from the next state so the line register changes on the
    // same edge as the state and never glitches
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = sreg_d[0];
      S_PARITY: tx_d = (PARITY == 2) ? par_d : ~par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_drain.sv
// Randomised bench for uart_tx_drain: four instances with different framing,
// a queue-based FIFO and a frame-bit-list reference model checked every cycle.
module tb_uart_tx_drain;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] empty_v = 4'hF;
  logic [7:0] r_data_v [4];
  logic [3:0] rd_v, tx_v, busy_v, done_v;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx_drain #(
      .DBIT(8),
      .CLKS_PER_BIT(CPB),
      .PARITY((g == 1) ? 2 : ((g == 2) ? 1 : 0)),
      .STOP_BITS((g == 3) ? 2 : 1)
    ) u_dut (
      .clk(clk),
      .reset(reset),
      .empty(empty_v[g]),
      .r_data(r_data_v[g]),
      .rd(rd_v[g]),
      .tx(tx_v[g]),
      .tx_busy(busy_v[g]),
      .tx_done_tick(done_v[g])
    );
  end

  function automatic int par_of(input int ch);
    return (ch == 1) ? 2 : ((ch == 2) ? 1 : 0);
  endfunction

  function automatic int stop_of(input int ch);
    return (ch == 3) ? 2 : 1;
  endfunction

  function automatic int frame_len(input int ch);
    return (1 + 8 + ((par_of(ch) != 0) ? 1 : 0) + stop_of(ch)) * CPB;
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // environment and reference model state
  int         act = 0;
  logic [7:0] fq[$];
  logic       fbits[$];
  int         flen = 0;
  int         pos = -1;
  int         cyc = 0;
  logic       pop_pend = 1'b0;
  logic       rst_drive = 1'b0;
  logic       jitter = 1'b0;
  int         rd_log[$];
  int         last_pop = 0;
  int         last_done = 0;
  int         n_done = 0;

  task automatic build_frame(input logic [7:0] b);
    logic p;
    fbits.delete();
    fbits.push_back(1'b0);
    for (int i = 0; i < 8; i++) fbits.push_back(b[i]);
    p = ^b;
    if (par_of(act) == 2) fbits.push_back(p);
    else if (par_of(act) == 1) fbits.push_back(~p);
    for (int s = 0; s < stop_of(act); s++) fbits.push_back(1'b1);
    flen = fbits.size() * CPB;
  endtask

  task automatic cycle();
    logic e_rd, e_tx, e_busy, e_done;
    @(posedge clk);
    #1;
    if (pop_pend && fq.size() > 0) void'(fq.pop_front());
    reset = rst_drive;
    for (int c = 0; c < 4; c++) if (c != act) empty_v[c] = 1'b1;
    if (jitter && pos >= 0) begin
      empty_v[act]  = 1'($urandom_range(0, 1));
      r_data_v[act] = 8'($urandom);
    end else begin
      empty_v[act]  = (fq.size() == 0);
      r_data_v[act] = (fq.size() > 0) ? fq[0] : 8'($urandom);
    end
    @(negedge clk);
    if (!reset) begin
      pos = -1;
      e_rd = 1'b0; e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
    end else if (pos < 0) begin
      e_rd = ~empty_v[act]; e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
    end else begin
      e_rd = 1'b0; e_tx = fbits[pos / CPB]; e_busy = 1'b1; e_done = (pos == flen - 1);
    end
    chk("rd", rd_v[act], e_rd);
    chk("tx", tx_v[act], e_tx);
    chk("tx_busy", busy_v[act], e_busy);
    chk("tx_done_tick", done_v[act], e_done);
    if (rd_v[act]) begin
      rd_log.push_back(cyc);
      last_pop = cyc;
    end
    if (done_v[act]) begin
      last_done = cyc;
      n_done++;
    end
    pop_pend = rd_v[act];
    if (reset) begin
      if (pos < 0) begin
        if (e_rd) begin
          build_frame(r_data_v[act]);
          pos = 0;
        end
      end else if (pos == flen - 1) begin
        pos = -1;
      end else begin
        pos++;
      end
    end
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((fq.size() != 0 || pos >= 0) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_within_budget", n < budget, 1'b1);
    cycle();
  endtask

  initial begin
    int n, d0;
    for (int c = 0; c < 4; c++) r_data_v[c] = 8'h00;

    // held in reset, first with the FIFO empty, then with a byte waiting
    repeat (3) cycle();
    fq.push_back(8'hA5);
    repeat (3) cycle();
    rd_log.delete();
    rst_drive = 1'b1;
    drain(200);
    chk("a5_pop_count", rd_log.size(), 1);
    chk("a5_done_latency", last_done - last_pop, 40);

    // back-to-back frames
    rd_log.delete();
    fq.push_back(8'h01); fq.push_back(8'h02); fq.push_back(8'h03);
    drain(400);
    chk("b2b_pop_count", rd_log.size(), 3);
    for (int i = 1; i < rd_log.size(); i++)
      chk("b2b_pop_gap", rd_log[i] - rd_log[i-1], frame_len(0) + 1);

    // 0x07 with even parity, odd parity and two stop bits
    for (int c = 1; c < 4; c++) begin
      act = c;
      fq.push_back(8'h07);
      drain(200);
      chk("p07_done_latency", last_done - last_pop, frame_len(c));
    end

    // random bytes on every framing variant
    for (int c = 0; c < 4; c++) begin
      act = c;
      rd_log.delete();
      for (int k = 0; k < 3; k++) fq.push_back(8'($urandom));
      drain(600);
      chk("rand_pop_count", rd_log.size(), 3);
      chk("rand_pop_gap", rd_log[2] - rd_log[1], frame_len(c) + 1);
    end

    // reset during data bit 3 of 0xFF, then 0x55 from the FIFO after release
    act = 0;
    d0 = n_done;
    fq.push_back(8'hFF);
    n = 0;
    while (pos != 4 * CPB + 1 && n < 200) begin
      cycle();
      n++;
    end
    chk("rst_reached_bit3", pos, 4 * CPB + 1);
    fq.push_back(8'h55);
    rst_drive = 1'b0;
    repeat (3) cycle();
    chk("rst_no_done", n_done - d0, 0);
    rd_log.delete();
    rst_drive = 1'b1;
    cycle();
    chk("rst_release_pop", rd_log.size(), 1);
    drain(200);
    chk("rst_done_count", n_done - d0, 1);

    // empty toggling and r_data changing while a frame is in flight
    for (int c = 0; c < 4; c += 3) begin
      act = c;
      jitter = 1'b1;
      rd_log.delete();
      fq.push_back(8'($urandom));
      fq.push_back(8'($urandom));
      drain(400);
      jitter = 1'b0;
      chk("jitter_pop_count", rd_log.size(), 2);
      chk("jitter_pop_gap", rd_log[1] - rd_log[0], frame_len(c) + 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
